// File: rtl/tob_feed_tx_if.sv
// tob_feed_tx_if -- update and transmit channels of tob_feed_tx.
//   i_upd_*      : top-of-book update (valid/ready handshake), driven by master
//   o_upd_ready  : update accepted when valid and ready are both high
//   o_data_valid : one-cycle beat toward the volatility engine
//   o_stock_id / o_best_ask / o_best_bid : beat payload, held between beats
// The slave modport is the tob_feed_tx side.
interface tob_feed_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STOCKS = 4
);
  localparam int SW = $clog2(NUM_STOCKS);

  logic                  i_upd_valid;
  logic                  o_upd_ready;
  logic [SW-1:0]         i_upd_stock_id;
  logic [DATA_WIDTH-1:0] i_upd_best_ask;
  logic [DATA_WIDTH-1:0] i_upd_best_bid;

  logic                  o_data_valid;
  logic [SW-1:0]         o_stock_id;
  logic [DATA_WIDTH-1:0] o_best_ask;
  logic [DATA_WIDTH-1:0] o_best_bid;

  modport master (
    output i_upd_valid, i_upd_stock_id, i_upd_best_ask, i_upd_best_bid,
    input  o_upd_ready, o_data_valid, o_stock_id, o_best_ask, o_best_bid
  );

  modport slave (
    input  i_upd_valid, i_upd_stock_id, i_upd_best_ask, i_upd_best_bid,
    output o_upd_ready, o_data_valid, o_stock_id, o_best_ask, o_best_bid
  );
endinterface

// File: rtl/tob_feed_tx.sv
// tob_feed_tx -- coalescing top-of-book feed transmitter.
// Keeps one ask/bid shadow pair and a pending flag per stock, and drains pending
// stocks round-robin toward the volatility engine, one beat per enabled cycle.
// A buffer-size reconfiguration first drains all pending stocks (updates
// blocked), then applies the new size/reciprocal in a one-cycle CFG state.
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   bus (slave)           : update handshake in, transmit beat out
//   i_tx_enable           : downstream permits a beat this cycle
//   i_cfg_we, i_cfg_*     : reconfiguration request and new values
//   o_buffer_size(_reciprocal) : active configuration
//   o_pending             : per-stock untransmitted-update flags
//   o_coalesce_count, o_reject_count : saturating event counters
// Optional feature: define TOB_CROSSED_FILTER_EN to discard crossed/zero quotes.
module tob_feed_tx #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          NUM_STOCKS   = 4,
  parameter int          BUFFER_SIZE  = 32,
  parameter int          FP_WORD_SIZE = 64,
  parameter logic [63:0] RECIP_RESET  = 64'h0800_0000_0000_0000
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  tob_feed_tx_if.slave            bus,
  input  logic                    i_tx_enable,
  input  logic                    i_cfg_we,
  input  logic [DATA_WIDTH-1:0]   i_cfg_buffer_size,
  input  logic [FP_WORD_SIZE-1:0] i_cfg_buffer_size_reciprocal,
  output logic [DATA_WIDTH-1:0]   o_buffer_size,
  output logic [FP_WORD_SIZE-1:0] o_buffer_size_reciprocal,
  output logic [NUM_STOCKS-1:0]   o_pending,
  output logic [15:0]             o_coalesce_count,
  output logic [15:0]             o_reject_count
);
  localparam int SW = $clog2(NUM_STOCKS);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CFG} state_e;

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic [SW-1:0]           ptr_q, ptr_d;
  logic [NUM_STOCKS-1:0]   pend_q, pend_d;
  logic [DATA_WIDTH-1:0]   ask_q [NUM_STOCKS];
  logic [DATA_WIDTH-1:0]   ask_d [NUM_STOCKS];
  logic [DATA_WIDTH-1:0]   bid_q [NUM_STOCKS];
  logic [DATA_WIDTH-1:0]   bid_d [NUM_STOCKS];
  logic                    dv_q, dv_d;
  logic [SW-1:0]           sid_q, sid_d;
  logic [DATA_WIDTH-1:0]   oask_q, oask_d;
  logic [DATA_WIDTH-1:0]   obid_q, obid_d;
  logic [DATA_WIDTH-1:0]   hold_size_q, hold_size_d;
  logic [FP_WORD_SIZE-1:0] hold_recip_q, hold_recip_d;
  logic [DATA_WIDTH-1:0]   size_q, size_d;
  logic [FP_WORD_SIZE-1:0] recip_q, recip_d;
  logic [15:0]             coal_q, coal_d;
  logic [15:0]             rej_q, rej_d;

  logic                    upd_reject;
  logic                    accept;
  logic                    sel_found;
  logic [SW-1:0]           sel_idx;
  logic [SW-1:0]           scan_idx;
  logic                    tx_fire;

`ifdef TOB_CROSSED_FILTER_EN
  assign upd_reject = (bus.i_upd_best_bid >= bus.i_upd_best_ask) ||
                      (bus.i_upd_best_bid == '0) || (bus.i_upd_best_ask == '0);
`else
  assign upd_reject = 1'b0;
`endif

  assign accept = bus.i_upd_valid && ready_q;

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    ptr_d        = ptr_q;
    pend_d       = pend_q;
    ask_d        = ask_q;
    bid_d        = bid_q;
    dv_d         = 1'b0;
    sid_d        = sid_q;
    oask_d       = oask_q;
    obid_d       = obid_q;
    hold_size_d  = hold_size_q;
    hold_recip_d = hold_recip_q;
    size_d       = size_q;
    recip_d      = recip_q;
    coal_d       = coal_q;
    rej_d        = rej_q;
    sel_found    = 1'b0;
    sel_idx      = '0;
    scan_idx     = '0;

    // First pending stock at or after the pointer; SW-bit add wraps modulo NUM_STOCKS.
    for (int unsigned i = 0; i < NUM_STOCKS; i++) begin
      scan_idx = ptr_q + SW'(i);
      if (!sel_found && pend_q[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end

    tx_fire = (state_q != ST_CFG) && i_tx_enable && sel_found;
    if (tx_fire) begin
      dv_d            = 1'b1;
      sid_d           = sel_idx;
      oask_d          = ask_q[sel_idx];
      obid_d          = bid_q[sel_idx];
      pend_d[sel_idx] = 1'b0;
      ptr_d           = sel_idx + SW'(1);
    end

    // Update applied after the clear so a same-cycle write to the selected
    // stock re-arms its pending bit; the beat already carries the old shadow.
    if (accept) begin
      if (upd_reject) begin
        rej_d = (rej_q == '1) ? rej_q : rej_q + 16'd1;
      end else begin
        if (pend_d[bus.i_upd_stock_id])
          coal_d = (coal_q == '1) ? coal_q : coal_q + 16'd1;
        ask_d[bus.i_upd_stock_id]  = bus.i_upd_best_ask;
        bid_d[bus.i_upd_stock_id]  = bus.i_upd_best_bid;
        pend_d[bus.i_upd_stock_id] = 1'b1;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (i_cfg_we) begin
          hold_size_d  = i_cfg_buffer_size;
          hold_recip_d = i_cfg_buffer_size_reciprocal;
          state_d      = ST_DRAIN;
          ready_d      = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Leave as soon as the final beat is issued, not a cycle later.
        if (pend_d == '0) state_d = ST_CFG;
      end
      ST_CFG: begin
        size_d  = hold_size_q;
        recip_d = hold_recip_q;
        state_d = ST_RUN;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_RUN;
      ready_q      <= 1'b1;
      ptr_q        <= '0;
      pend_q       <= '0;
      ask_q        <= '{default: '0};
      bid_q        <= '{default: '0};
      dv_q         <= 1'b0;
      sid_q        <= '0;
      oask_q       <= '0;
      obid_q       <= '0;
      hold_size_q  <= '0;
      hold_recip_q <= '0;
      size_q       <= DATA_WIDTH'(BUFFER_SIZE);
      recip_q      <= FP_WORD_SIZE'(RECIP_RESET);
      coal_q       <= '0;
      rej_q        <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      ptr_q        <= ptr_d;
      pend_q       <= pend_d;
      ask_q        <= ask_d;
      bid_q        <= bid_d;
      dv_q         <= dv_d;
      sid_q        <= sid_d;
      oask_q       <= oask_d;
      obid_q       <= obid_d;
      hold_size_q  <= hold_size_d;
      hold_recip_q <= hold_recip_d;
      size_q       <= size_d;
      recip_q      <= recip_d;
      coal_q       <= coal_d;
      rej_q        <= rej_d;
    end
  end

  // ready_q reloads to 1 under reset; gating with i_reset keeps it low during reset.
  assign bus.o_upd_ready         = ready_q && !i_reset;
  assign bus.o_data_valid        = dv_q;
  assign bus.o_stock_id          = sid_q;
  assign bus.o_best_ask          = oask_q;
  assign bus.o_best_bid          = obid_q;
  assign o_buffer_size           = size_q;
  assign o_buffer_size_reciprocal = recip_q;
  assign o_pending               = pend_q;
  assign o_coalesce_count        = coal_q;
  assign o_reject_count          = rej_q;
endmodule

// File: tb/tb_tob_feed_tx.sv
// Self-checking bench for tob_feed_tx: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a
// behavioural model of the feed.
module tb_tob_feed_tx;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam logic [63:0] RECIP0 = 64'h0800_0000_0000_0000;
  localparam logic [63:0] RECIP1 = 64'h0400_0000_0000_0000;

  logic        clk;
  logic        rst, tx_en, cfg_we;
  logic [31:0] cfg_size;
  logic [63:0] cfg_recip;
  logic [31:0] size_o;
  logic [63:0] recip_o;
  logic [3:0]  pend_o;
  logic [15:0] coal_o, rej_o;

  tob_feed_tx_if #(.DATA_WIDTH(DW), .NUM_STOCKS(NS)) bus ();

  tob_feed_tx #(
    .DATA_WIDTH(DW), .NUM_STOCKS(NS), .BUFFER_SIZE(32),
    .FP_WORD_SIZE(64), .RECIP_RESET(RECIP0)
  ) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus),
    .i_tx_enable(tx_en), .i_cfg_we(cfg_we),
    .i_cfg_buffer_size(cfg_size), .i_cfg_buffer_size_reciprocal(cfg_recip),
    .o_buffer_size(size_o), .o_buffer_size_reciprocal(recip_o),
    .o_pending(pend_o), .o_coalesce_count(coal_o), .o_reject_count(rej_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_ask [NS];
  int unsigned m_bid [NS];
  bit          m_pend [NS];
  int          m_ptr;
  bit          m_draining, m_cfg_cycle, m_init;
  logic [63:0] m_hold_size, m_hold_recip, m_size, m_recip;
  int unsigned m_coal, m_rej;
  bit          e_dv;
  int          e_sid;
  int unsigned e_ask, e_bid;
  int          sel, uid;
  bit          acc, rej, any_pend;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NS; k++) begin m_ask[k] = 0; m_bid[k] = 0; m_pend[k] = 0; end
      m_ptr = 0; m_draining = 0; m_cfg_cycle = 0; m_init = 1;
      m_size = 32; m_recip = RECIP0; m_coal = 0; m_rej = 0;
      e_dv = 0; e_sid = 0; e_ask = 0; e_bid = 0;
    end else if (m_init) begin
      acc = bus.i_upd_valid && !m_draining && !m_cfg_cycle;
      sel = -1;
      e_dv = 0;
      if (!m_cfg_cycle && tx_en)
        for (int k = 0; k < NS; k++)
          if (sel < 0 && m_pend[(m_ptr + k) % NS]) sel = (m_ptr + k) % NS;
      if (sel >= 0) begin
        e_dv = 1; e_sid = sel; e_ask = m_ask[sel]; e_bid = m_bid[sel];
        m_pend[sel] = 0; m_ptr = (sel + 1) % NS;
      end
      uid = int'(bus.i_upd_stock_id);
`ifdef TOB_CROSSED_FILTER_EN
      rej = (bus.i_upd_best_bid >= bus.i_upd_best_ask) ||
            (bus.i_upd_best_bid == 0) || (bus.i_upd_best_ask == 0);
`else
      rej = 0;
`endif
      if (acc && rej) begin
        if (m_rej < 65535) m_rej++;
      end else if (acc) begin
        if (m_pend[uid] && m_coal < 65535) m_coal++;
        m_ask[uid] = bus.i_upd_best_ask; m_bid[uid] = bus.i_upd_best_bid; m_pend[uid] = 1;
      end
      any_pend = 0;
      for (int k = 0; k < NS; k++) any_pend |= m_pend[k];
      if (m_cfg_cycle) begin
        m_size = m_hold_size; m_recip = m_hold_recip; m_cfg_cycle = 0;
      end else if (m_draining) begin
        if (!any_pend) begin m_draining = 0; m_cfg_cycle = 1; end
      end else if (cfg_we) begin
        m_hold_size = cfg_size; m_hold_recip = cfg_recip; m_draining = 1;
      end
    end
  end

  logic [3:0] m_pend_vec;
  always @(negedge clk) begin
    if (m_init) begin
      for (int k = 0; k < NS; k++) m_pend_vec[k] = m_pend[k];
      check("m_ready", bus.o_upd_ready, !m_draining && !m_cfg_cycle && !rst);
      check("m_dv", bus.o_data_valid, e_dv);
      check("m_sid", bus.o_stock_id, e_sid);
      check("m_ask", bus.o_best_ask, e_ask);
      check("m_bid", bus.o_best_bid, e_bid);
      check("m_pend", pend_o, m_pend_vec);
      check("m_size", size_o, m_size);
      check("m_recip", recip_o, m_recip);
      check("m_coal", coal_o, m_coal);
      check("m_rej", rej_o, m_rej);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input int id, input int unsigned a, input int unsigned b);
    bus.i_upd_valid    = 1'b1;
    bus.i_upd_stock_id = 2'(id);
    bus.i_upd_best_ask = a;
    bus.i_upd_best_bid = b;
  endtask

  task automatic idle();
    bus.i_upd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tx_en = 1'b0; cfg_we = 1'b0; idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tx_en = 1'b0; cfg_we = 1'b0; cfg_size = '0; cfg_recip = '0;
    bus.i_upd_valid = 1'b0; bus.i_upd_stock_id = '0;
    bus.i_upd_best_ask = '0; bus.i_upd_best_bid = '0;
    tick(); tick();

    // reset state
    check("rst_ready", bus.o_upd_ready, 0);
    check("rst_dv", bus.o_data_valid, 0);
    check("rst_size", size_o, 32);
    check("rst_recip", recip_o, RECIP0);
    check("rst_pend", pend_o, 0);
    check("rst_coal", coal_o, 0);
    rst = 1'b0; #1;
    check("rst_ready_after", bus.o_upd_ready, 1);

    // single update, two-cycle latency
    tx_en = 1'b1; upd(2, 105, 100); tick(); idle();
    check("lat_pend", pend_o, 4'b0100);
    check("lat_dv_early", bus.o_data_valid, 0);
    tick();
    check("lat_dv", bus.o_data_valid, 1);
    check("lat_sid", bus.o_stock_id, 2);
    check("lat_ask", bus.o_best_ask, 105);
    check("lat_bid", bus.o_best_bid, 100);
    check("lat_pend_after", pend_o, 0);

    // stall, coalesce, round-robin order
    do_reset();
    upd(3, 30, 20); tick(); upd(0, 10, 5); tick(); upd(1, 11, 6); tick();
    upd(3, 7, 2); tick(); idle();
    check("rr_coal", coal_o, 1);
    check("rr_pend", pend_o, 4'b1011);
    tx_en = 1'b1; tick();
    check("rr_b0_sid", bus.o_stock_id, 0);
    check("rr_b0_ask", bus.o_best_ask, 10);
    tick();
    check("rr_b1_sid", bus.o_stock_id, 1);
    check("rr_b1_ask", bus.o_best_ask, 11);
    tick();
    check("rr_b2_sid", bus.o_stock_id, 3);
    check("rr_b2_ask", bus.o_best_ask, 7);
    check("rr_b2_bid", bus.o_best_bid, 2);
    tick();
    check("rr_idle_dv", bus.o_data_valid, 0);
    check("rr_hold_ask", bus.o_best_ask, 7);
    check("rr_hold_sid", bus.o_stock_id, 3);

    // update collides with selection of the same stock
    do_reset();
    upd(1, 50, 40); tick();
    tx_en = 1'b1; upd(1, 60, 45); tick(); idle();
    check("col_dv", bus.o_data_valid, 1);
    check("col_old_ask", bus.o_best_ask, 50);
    check("col_old_bid", bus.o_best_bid, 40);
    check("col_pend", pend_o, 4'b0010);
    check("col_coal", coal_o, 0);
    tick();
    check("col_new_sid", bus.o_stock_id, 1);
    check("col_new_ask", bus.o_best_ask, 60);
    check("col_new_bid", bus.o_best_bid, 45);
    check("col_pend_after", pend_o, 0);

    // reconfiguration drains first; cfg_we while draining is ignored
    do_reset();
    upd(0, 20, 10); tick(); upd(2, 22, 12); tick(); idle();
    cfg_we = 1'b1; cfg_size = 64; cfg_recip = RECIP1; tick();
    check("cfg_ready_drain", bus.o_upd_ready, 0);
    check("cfg_pend", pend_o, 4'b0101);
    cfg_size = 128; tx_en = 1'b1; tick(); cfg_we = 1'b0;
    check("cfg_b0_sid", bus.o_stock_id, 0);
    check("cfg_b0_ready", bus.o_upd_ready, 0);
    tick();
    check("cfg_b1_sid", bus.o_stock_id, 2);
    check("cfg_b1_ask", bus.o_best_ask, 22);
    check("cfg_b1_size", size_o, 32);
    check("cfg_b1_ready", bus.o_upd_ready, 0);
    tick();
    check("cfg_size", size_o, 64);
    check("cfg_recip", recip_o, RECIP1);
    check("cfg_ready", bus.o_upd_ready, 1);

    // equal bid/ask quote
    do_reset();
    tx_en = 1'b1; upd(1, 100, 100); tick(); idle(); tick();
`ifdef TOB_CROSSED_FILTER_EN
    check("flt_dv", bus.o_data_valid, 0);
    check("flt_rej", rej_o, 1);
    check("flt_pend", pend_o, 0);
`else
    check("flt_dv", bus.o_data_valid, 1);
    check("flt_ask", bus.o_best_ask, 100);
    check("flt_rej", rej_o, 0);
`endif

    // reset during drain discards held config and pending updates
    do_reset();
    upd(1, 9, 3); tick(); idle();
    cfg_we = 1'b1; cfg_size = 64; cfg_recip = RECIP1; tick(); cfg_we = 1'b0;
    check("rd_ready_drain", bus.o_upd_ready, 0);
    rst = 1'b1; tick();
    check("rd_pend", pend_o, 0);
    check("rd_size", size_o, 32);
    check("rd_ready_in_rst", bus.o_upd_ready, 0);
    rst = 1'b0; #1;
    check("rd_ready", bus.o_upd_ready, 1);
    tick();
    check("rd_size_kept", size_o, 32);

    // randomized run, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      rst                = ($urandom_range(0, 99) == 0);
      tx_en              = ($urandom_range(0, 9) < 6);
      cfg_we             = ($urandom_range(0, 39) == 0);
      cfg_size           = $urandom;
      cfg_recip          = {$urandom, $urandom};
      bus.i_upd_valid    = $urandom_range(0, 1) == 1;
      bus.i_upd_stock_id = 2'($urandom_range(0, 3));
      bus.i_upd_best_ask = $urandom_range(0, 15);
      bus.i_upd_best_bid = $urandom_range(0, 15);
      tick();
    end
    idle(); rst = 1'b0; cfg_we = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/tob_feed_tx.md
TOB_FEED_TX -- requirements
Module: tob_feed_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 32, price word width.
REQ-002 Parameter NUM_STOCKS, default 4, number of stocks; power of 2, at least 2.
REQ-003 Parameter BUFFER_SIZE, default 32, reset value of o_buffer_size.
REQ-004 Parameter FP_WORD_SIZE, default 64, reciprocal word width, Q0.FP_WORD_SIZE format.
REQ-005 Parameter RECIP_RESET, default 64'h0800_0000_0000_0000 (1/32), reset value of o_buffer_size_reciprocal.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 i_clk  in  1  clock; all logic rising-edge.
REQ-008 i_reset  in  1  synchronous active-high reset.
REQ-009 i_upd_valid  in  1  order-book top-of-book update valid.
REQ-010 o_upd_ready  out  1  update accepted when valid and ready are both high.
REQ-011 i_upd_stock_id  in  clog2(NUM_STOCKS)  stock of the update.
REQ-012 i_upd_best_ask / i_upd_best_bid  in  DATA_WIDTH each  new best prices.
REQ-013 i_tx_enable  in  1  downstream permits a transmit this cycle.
REQ-014 i_cfg_we  in  1  request a buffer-size reconfiguration (one-cycle pulse).
REQ-015 i_cfg_buffer_size / i_cfg_buffer_size_reciprocal  in  DATA_WIDTH / FP_WORD_SIZE  new configuration.
REQ-016 o_data_valid, o_stock_id, o_best_ask, o_best_bid  out  1 / clog2(NUM_STOCKS) / DATA_WIDTH / DATA_WIDTH  transmit beat to the volatility engine.
REQ-017 o_buffer_size / o_buffer_size_reciprocal  out  DATA_WIDTH / FP_WORD_SIZE  active configuration.
REQ-018 o_pending  out  NUM_STOCKS  per-stock untransmitted-update flags.
REQ-019 o_coalesce_count / o_reject_count  out  16 each  saturating event counters.

Function
REQ-020 The block SHALL hold one ask/bid shadow register pair and one pending bit per stock; an accepted update overwrites that stock's shadow pair and sets its pending bit.
REQ-021 The block SHALL implement FSM RUN -> DRAIN -> CFG -> RUN:
- RUN: o_upd_ready=1.
- i_cfg_we in RUN: latch the configuration inputs into hold registers and go to DRAIN.
- DRAIN: o_upd_ready=0; transmit continues; when no pending bit is set, go to CFG.
- CFG (one cycle): copy the hold registers to the o_buffer_size outputs, then return to RUN.
- i_cfg_we in DRAIN or CFG: ignored.
REQ-022 In RUN or DRAIN, with i_tx_enable=1 and at least one pending bit set, the block SHALL select the first pending stock at or after the round-robin pointer (wrapping modulo NUM_STOCKS).
- Register the selected stock's shadow values on the o_ ports with o_data_valid=1 on the next edge.
- Clear the selected stock's pending bit.
- Set the pointer to selected+1 mod NUM_STOCKS.
REQ-023 o_data_valid SHALL be a single-cycle pulse per beat; all o_ data ports SHALL hold their values when o_data_valid=0.
REQ-024 An update accepted in cycle N SHALL produce its earliest o_data_valid in cycle N+2.
REQ-025 If the selected stock receives an update in the same cycle, the old shadow values SHALL be transmitted, and the pending bit SHALL remain set (set wins) with the new values stored.
REQ-026 An accepted update to a stock whose pending bit is set and not cleared that cycle SHALL increment o_coalesce_count, saturating at 16'hFFFF.
REQ-027 i_tx_enable=0 SHALL stall transmission without losing pending state; updates continue to coalesce.

Reset
REQ-028 On i_reset=1 at a clock edge, the block SHALL set:
- FSM to RUN, pointer to 0, all pending bits and shadow registers to 0.
- o_data_valid, o_stock_id, o_best_ask, o_best_bid, o_coalesce_count, o_reject_count to 0.
- o_buffer_size to BUFFER_SIZE and o_buffer_size_reciprocal to RECIP_RESET.
- o_upd_ready to 0 during reset, then 1 from the first cycle after reset.
REQ-029 Reset asserted mid-DRAIN SHALL discard the held configuration and all pending updates.

Configuration
REQ-030 With macro TOB_CROSSED_FILTER_EN defined, an accepted update with bid >= ask, bid == 0, or ask == 0 SHALL be discarded: no shadow write, no pending set, o_reject_count incremented (saturating).
REQ-031 Without TOB_CROSSED_FILTER_EN, all accepted updates SHALL be stored, and o_reject_count SHALL be constant 0.

Verification
REQ-032 Scenario: update stock 2 with ask=105, bid=100 at cycle N, i_tx_enable=1 -> o_data_valid in cycle N+2 with o_stock_id=2, o_best_ask=105, o_best_bid=100; o_pending=0 afterwards.
REQ-033 Scenario: i_tx_enable=0; updates to stocks 3, 0, 1, then 3 again with ask=7 -> o_coalesce_count=1; after enabling, beats are transmitted in order 0, 1, 3, with stock 3 carrying ask=7.
REQ-034 Scenario: stocks 0 and 2 pending; i_cfg_we with size 64, reciprocal 64'h0400_0000_0000_0000 -> o_upd_ready=0 until both beats are sent, then o_buffer_size=64 one cycle later, then o_upd_ready=1.
REQ-035 Scenario: update to stock 1 in the same cycle stock 1 is selected -> old values transmitted, pending[1] stays 1, and the new values are sent on a later beat.
REQ-036 Scenario: with TOB_CROSSED_FILTER_EN defined, update bid=100, ask=100 -> no beat, o_reject_count=1; without the macro -> one beat is sent and o_reject_count=0.
REQ-037 Scenario: i_reset asserted during DRAIN -> next cycle o_pending=0, o_buffer_size=32, FSM in RUN.
